// File: rtl/multiword_add_ctrl_pkg.sv
// rtl/multiword_add_ctrl_pkg.sv - shared FSM encoding and index-width helper for multiword_add_ctrl
package multiword_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the chunk index; at least one bit so NUM_CHUNKS=1 still has a register.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/multiword_add_ctrl_chunk_adder.sv
// rtl/multiword_add_ctrl_chunk_adder.sv - combinational CHUNK_W-bit ripple adder slice
// c_msb is the carry into the top bit, used to derive signed overflow.
module chunk_adder #(
  parameter int CHUNK_W = 4
) (
  output logic [CHUNK_W-1:0] sum,
  output logic               c_out,
  output logic               c_msb,
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               c_in
);

  always_comb begin
    logic c;
    sum   = '0;
    c_msb = 1'b0;
    c     = c_in;
    for (int i = 0; i < CHUNK_W; i++) begin
      if (i == CHUNK_W - 1) c_msb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    c_out = c;
  end

endmodule

// File: rtl/multiword_add_ctrl.sv
// rtl/multiword_add_ctrl.sv - W-bit add sequenced over NUM_CHUNKS cycles on one shared adder slice
// Optional signed-overflow output ovf is enabled by defining MULTIWORD_ADD_OVF_EN.
module multiword_add_ctrl
  import multiword_add_ctrl_pkg::*;
#(
  parameter  int CHUNK_W    = 4,
  parameter  int NUM_CHUNKS = 4,
  localparam int W          = CHUNK_W * NUM_CHUNKS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         busy
`ifdef MULTIWORD_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int            IW   = idx_width(NUM_CHUNKS);
  localparam logic [IW-1:0] LAST = IW'(NUM_CHUNKS - 1);

  state_t state, state_next;

  logic [W-1:0]       a_r, b_r;
  logic               carry;
  logic [IW-1:0]      idx;
  logic [CHUNK_W-1:0] slice_a, slice_b, slice_sum;
  logic               slice_cout, slice_cmsb;

  assign slice_a = a_r[int'(idx)*CHUNK_W +: CHUNK_W];
  assign slice_b = b_r[int'(idx)*CHUNK_W +: CHUNK_W];

  chunk_adder #(.CHUNK_W(CHUNK_W)) u_chunk_adder (
    .sum   (slice_sum),
    .c_out (slice_cout),
    .c_msb (slice_cmsb),
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (idx == LAST) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operands are captured once so the requester may move on after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
`ifdef MULTIWORD_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= c_in;
            idx   <= '0;
            sum   <= '0;
          end
        end
        ST_RUN: begin
          sum[int'(idx)*CHUNK_W +: CHUNK_W] <= slice_sum;
          carry <= slice_cout;
          if (idx == LAST) begin
            c_out <= slice_cout;
`ifdef MULTIWORD_ADD_OVF_EN
            ovf   <= slice_cmsb ^ slice_cout;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef MULTIWORD_ADD_OVF_EN
  logic unused_slice_cmsb;
  assign unused_slice_cmsb = slice_cmsb;
`endif

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// tb/tb_multiword_add_ctrl.sv - self-checking bench for multiword_add_ctrl
module tb_multiword_add_ctrl;

  localparam int CW = 4;
  localparam int N  = 4;
  localparam int W  = CW * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         c_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, c_out, busy;
  logic [W-1:0] sum;
`ifdef MULTIWORD_ADD_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multiword_add_ctrl #(.CHUNK_W(CW), .NUM_CHUNKS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
`ifdef MULTIWORD_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic [W:0] r);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Reference model: one outstanding add; result visible N edges after accept.
  bit          pend = 1'b0;
  int          cyc = 0;
  int          e0 = 0;
  logic [W:0]  exp_res = '0;
  logic        exp_ovf = 1'b0;
  int          acc_q[$];

  always @(negedge rst_n) pend = 1'b0;

  always @(posedge clk) begin : model
    bit ov_pre;
    ov_pre = pend && (cyc >= e0 + N);
    cyc++;
    if (rst_n) begin
      if (ov_pre && out_ready) begin
        pend = 1'b0;
      end else if (!pend && in_valid) begin
        pend    = 1'b1;
        e0      = cyc;
        exp_res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
        exp_ovf = signed_ovf(a, b, exp_res);
        acc_q.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin : compare
    bit exp_ov;
    exp_ov = pend && (cyc >= e0 + N);
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    chk("in_ready", {31'd0, in_ready}, {31'd0, !pend});
    chk("busy", {31'd0, busy}, {31'd0, pend});
    if (exp_ov && out_valid) begin
      chk("result", {15'd0, c_out, sum}, {15'd0, exp_res});
`ifdef MULTIWORD_ADD_OVF_EN
      chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`endif
    end
    if (!rst_n) begin
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, c_out}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    a = x; b = y; c_in = ci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) chk("wait_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic add_expect(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic [W-1:0] es, input logic ec);
    int n;
    start(x, y, ci);
    wait_valid(n);
    chk({name, "_sum"}, {16'd0, sum}, {16'd0, es});
    chk({name, "_cout"}, {31'd0, c_out}, {31'd0, ec});
  endtask

  logic [W-1:0] va[4] = '{16'h0001, 16'h8000, 16'hABCD, 16'hFFFF};
  logic [W-1:0] vb[4] = '{16'h0002, 16'h8000, 16'h1234, 16'hFFFF};

  initial begin
    int n;
    int v;
    repeat (2) tick();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Carry ripples through every chunk.
    out_ready = 1'b1;
    start(16'hFFFF, 16'h0001, 1'b0);
    wait_valid(n);
    chk("latency", n, N);
    chk("t1_sum", {16'd0, sum}, 32'h0000);
    chk("t1_cout", {31'd0, c_out}, 32'd1);
    tick();
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t1_out_valid_drop", {31'd0, out_valid}, 32'd0);

    // Operands change after accept.
    start(16'h1234, 16'h4321, 1'b1);
    a = 16'hAAAA; b = 16'hAAAA;
    wait_valid(n);
    chk("t2_sum", {16'd0, sum}, 32'h5556);
    chk("t2_cout", {31'd0, c_out}, 32'd0);
    tick();

    // Backpressure in DONE with in_valid pulses ignored.
    out_ready = 1'b0;
    start(16'h00FF, 16'h0F01, 1'b0);
    wait_valid(n);
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      chk("t3_sum", {16'd0, sum}, 32'h1000);
      chk("t3_cout", {31'd0, c_out}, 32'd0);
      chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t3_out_valid_drop", {31'd0, out_valid}, 32'd0);

    // Reset mid-RUN abandons the add.
    start(16'hFFFF, 16'hFFFF, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_sum", {16'd0, sum}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    add_expect("t4_after", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
    tick();

`ifdef MULTIWORD_ADD_OVF_EN
    add_expect("ovf_a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    chk("ovf_a_ovf", {31'd0, ovf}, 32'd1);
    tick();
    add_expect("ovf_b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    chk("ovf_b_ovf", {31'd0, ovf}, 32'd1);
    tick();
    add_expect("ovf_c", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    chk("ovf_c_ovf", {31'd0, ovf}, 32'd0);
    tick();
`endif

    // Back-to-back: in_valid held high, out_ready high.
    acc_q.delete();
    v = 0;
    in_valid = 1'b1;
    for (int t = 0; t < 60 && v < 4; t++) begin
      a = va[v];
      b = vb[v];
      c_in = v[0];
      if (in_ready) begin
        tick();
        v++;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    wait_valid(n);
    tick();
    tick();
    chk("b2b_accepts", acc_q.size(), 4);
    for (int i = 1; i < acc_q.size(); i++)
      chk("b2b_spacing", acc_q[i] - acc_q[i-1], N + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
